switch_cfg_ctrl: RTL and testbench

Configuration controller for one routing-switch tile. It owns the 2-bit select registers that steer the tile's four 4:1 direction muxes (north, west, south, east outputs). It accepts ID-addressed configuration packets over a valid/ready stream into a shadow register. It commits the shadow atomically to the active selects only when the datapath is quiescent, and it answers readback requests.

---
 rtl/switch_cfg_ctrl.sv | 147 ++++++++++++++
 tb/tb_switch_cfg_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_cfg_ctrl.sv
// switch_cfg_ctrl: configuration controller for one routing-switch tile.
// Accepts ID-addressed packets into a shadow register. Commits the shadow
// atomically to the four 2-bit mux selects once the datapath is idle.
// Answers readback requests with {commit_cnt, shadow, active}.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   cfg_valid/ready    packet stream handshake (ready only while idle)
//   cfg_data           {target id, opcode, select payload}
//   dp_busy            datapath mid-transfer; defers a pending commit
//   sel_n/w/s/e        active mux selects
//   cfg_done           one-cycle pulse when a commit is applied
//   rsp_valid/ready    readback response handshake
//   rsp_data           {commit_cnt, shadow, active}
module switch_cfg_ctrl #(
    parameter int unsigned ID_W  = 4,
    parameter int unsigned MY_ID = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ID_W+9:0]   cfg_data,
    input  logic              dp_busy,
    output logic [1:0]        sel_n,
    output logic [1:0]        sel_w,
    output logic [1:0]        sel_s,
    output logic [1:0]        sel_e,
    output logic              cfg_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [23:0]       rsp_data
);

    localparam int unsigned SEL_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned RSP_W = CNT_W + 2 * SEL_W;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_COMMIT = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COMMIT_WAIT = 2'd1,
        RESP        = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   shadow_q, shadow_d;
    logic [SEL_W-1:0]   active_q, active_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [RSP_W-1:0]   rsp_data_q, rsp_data_d;

    logic [ID_W-1:0]    pkt_id;
    logic [1:0]         pkt_op;
    logic [SEL_W-1:0]   pkt_payload;
    logic               pkt_hit;

    // Packet field decode
    assign pkt_id      = cfg_data[ID_W+9:10];
    assign pkt_op      = cfg_data[9:8];
    assign pkt_payload = cfg_data[7:0];
    assign pkt_hit     = (pkt_id == ID_W'(MY_ID));

    // Next-state and next-register logic
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                // Foreign-ID packets are still consumed, just without effect
                if (cfg_valid && pkt_hit) begin
                    case (pkt_op)
                        OP_WRITE:  shadow_d = pkt_payload;
                        OP_COMMIT: state_d  = COMMIT_WAIT;
                        OP_READ: begin
                            rsp_data_d  = {cnt_q, shadow_q, active_q};
                            rsp_valid_d = 1'b1;
                            state_d     = RESP;
                        end
                        OP_CLEAR: begin
                            shadow_d = '0;
                            active_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            COMMIT_WAIT: begin
                if (!dp_busy) begin
                    active_d = shadow_q;
                    done_d   = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = IDLE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign sel_n     = active_q[1:0];
    assign sel_w     = active_q[3:2];
    assign sel_s     = active_q[5:4];
    assign sel_e     = active_q[7:6];
    assign cfg_done  = done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_switch_cfg_ctrl.sv
// tb_switch_cfg_ctrl: directed bench for switch_cfg_ctrl with a
// transaction-level reference model and a per-cycle output comparator.
module tb_switch_cfg_ctrl;

    localparam int unsigned ID_W  = 4;
    localparam int unsigned MY_ID = 3;

    localparam logic [1:0] WR = 2'b00;
    localparam logic [1:0] CM = 2'b01;
    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] CL = 2'b11;

    logic            clk;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [ID_W+9:0] cfg_data;
    logic            dp_busy;
    logic [1:0]      sel_n, sel_w, sel_s, sel_e;
    logic            cfg_done;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [23:0]     rsp_data;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    switch_cfg_ctrl #(.ID_W(ID_W), .MY_ID(MY_ID)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .dp_busy   (dp_busy),
        .sel_n     (sel_n),
        .sel_w     (sel_w),
        .sel_s     (sel_s),
        .sel_e     (sel_e),
        .cfg_done  (cfg_done),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: controller is "busy" while a commit is pending or
    // a response is outstanding; otherwise every offered packet is taken.
    logic [7:0]  m_shadow, m_active, m_cnt;
    logic        m_done, m_pend, m_rsp_out, m_xfer;
    logic [23:0] m_rsp_data;
    logic        m_ready;
    assign m_ready = !m_pend && !m_rsp_out;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_shadow   <= 8'h00;
            m_active   <= 8'h00;
            m_cnt      <= 8'h00;
            m_done     <= 1'b0;
            m_pend     <= 1'b0;
            m_rsp_out  <= 1'b0;
            m_rsp_data <= 24'h0;
            m_xfer     <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_xfer <= 1'b0;
            if (m_pend) begin
                if (!dp_busy) begin
                    m_active <= m_shadow;
                    m_cnt    <= 8'((int'(m_cnt) + 1) % 256);
                    m_done   <= 1'b1;
                    m_pend   <= 1'b0;
                end
            end else if (m_rsp_out) begin
                if (rsp_ready) m_rsp_out <= 1'b0;
            end else if (cfg_valid) begin
                m_xfer <= 1'b1;
                if (int'(cfg_data[13:10]) == MY_ID) begin
                    if (cfg_data[9:8] == WR) m_shadow <= cfg_data[7:0];
                    else if (cfg_data[9:8] == CM) m_pend <= 1'b1;
                    else if (cfg_data[9:8] == RD) begin
                        m_rsp_data <= {m_cnt, m_shadow, m_active};
                        m_rsp_out  <= 1'b1;
                    end else begin
                        m_shadow <= 8'h00;
                        m_active <= 8'h00;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("sel",       {24'h0, sel_e, sel_s, sel_w, sel_n}, {24'h0, m_active});
            chk("cfg_done",  {31'h0, cfg_done},  {31'h0, m_done});
            chk("cfg_ready", {31'h0, cfg_ready}, {31'h0, m_ready});
            chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_rsp_out});
            if (m_rsp_out) chk("rsp_data", {8'h0, rsp_data}, {8'h0, m_rsp_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] act_sel();
        return {24'h0, sel_e, sel_s, sel_w, sel_n};
    endfunction

    task automatic send(input logic [3:0] id, input logic [1:0] op, input logic [7:0] pl);
        int n;
        cfg_valid = 1'b1;
        cfg_data  = {id, op, pl};
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_xfer && n < 50);
        if (!m_xfer) chk("send_timeout", 32'(n), 32'd0);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [23:0] held;
        reset = 1'b0; cfg_valid = 1'b0; cfg_data = '0; dp_busy = 1'b0; rsp_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk_en = 1'b1;

        // Reset state
        chk("rst_sel", act_sel(), 32'h0);
        chk("rst_ready", {31'h0, cfg_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_data", {8'h0, rsp_data}, 32'h0);

        // WRITE 0xE4 then COMMIT with datapath idle
        send(4'd3, WR, 8'hE4);
        send(4'd3, CM, 8'h00);
        chk("cm_ready_low", {31'h0, cfg_ready}, 32'h0);
        tick();
        chk("cm_sel", act_sel(), 32'hE4);
        chk("cm_n", {30'h0, sel_n}, 32'h0);
        chk("cm_e", {30'h0, sel_e}, 32'h3);
        chk("cm_done", {31'h0, cfg_done}, 32'h1);
        tick();
        chk("cm_done_fall", {31'h0, cfg_done}, 32'h0);

        // READ with immediate consume
        send(4'd3, RD, 8'h00);
        chk("rd_data", {8'h0, rsp_data}, 32'h01E4E4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_drained", {31'h0, rsp_valid}, 32'h0);

        // CLEAR, rewrite, COMMIT deferred by 5 busy cycles
        send(4'd3, CL, 8'h00);
        chk("clr_sel", act_sel(), 32'h0);
        send(4'd3, WR, 8'hE4);
        dp_busy = 1'b1;
        send(4'd3, CM, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_sel", act_sel(), 32'h0);
            chk("busy_ready", {31'h0, cfg_ready}, 32'h0);
        end
        dp_busy = 1'b0;
        tick();
        chk("busy_commit", act_sel(), 32'hE4);
        chk("busy_done", {31'h0, cfg_done}, 32'h1);
        tick();
        chk("busy_done_fall", {31'h0, cfg_done}, 32'h0);

        // Foreign-ID packets are consumed without effect
        send(4'd5, WR, 8'hFF);
        chk("foreign_wr_ready", {31'h0, cfg_ready}, 32'h1);
        send(4'd5, CM, 8'h00);
        chk("foreign_cm_ready", {31'h0, cfg_ready}, 32'h1);
        tick();
        chk("foreign_sel", act_sel(), 32'hE4);
        chk("foreign_done", {31'h0, cfg_done}, 32'h0);

        // READ stalled by the consumer; a WRITE waits behind it
        send(4'd3, RD, 8'h00);
        held = rsp_data;
        chk("stall_rd_data", {8'h0, held}, 32'h02E4E4);
        cfg_valid = 1'b1;
        cfg_data  = {4'd3, WR, 8'h55};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_data", {8'h0, rsp_data}, {8'h0, held});
            chk("stall_no_xfer", {31'h0, m_xfer}, 32'h0);
            chk("stall_ready", {31'h0, cfg_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_xfer && n < 20);
        cfg_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("stall_wr_latency", 32'(n), 32'd2);
        send(4'd3, RD, 8'h00);
        chk("stall_wr_applied", {8'h0, rsp_data}, 32'h0255E4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Commit counter wrap after 256 commits, then CLEAR
        reset = 1'b0;
        tick();
        reset = 1'b1;
        send(4'd3, WR, 8'h9C);
        for (int i = 0; i < 256; i++) send(4'd3, CM, 8'h00);
        send(4'd3, RD, 8'h00);
        chk("wrap_rd", {8'h0, rsp_data}, 32'h009C9C);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        send(4'd3, CM, 8'h00);
        send(4'd3, CL, 8'h00);
        chk("wrap_clr_sel", act_sel(), 32'h0);
        send(4'd3, RD, 8'h00);
        chk("wrap_clr_rd", {8'h0, rsp_data}, 32'h010000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset while a commit is pending
        send(4'd3, WR, 8'h33);
        send(4'd3, CM, 8'h00);
        tick();
        chk("pre_rst_sel", act_sel(), 32'h33);
        send(4'd3, WR, 8'h66);
        dp_busy = 1'b1;
        send(4'd3, CM, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        #2;
        chk("rstcw_sel", act_sel(), 32'h0);
        chk("rstcw_done", {31'h0, cfg_done}, 32'h0);
        chk("rstcw_ready", {31'h0, cfg_ready}, 32'h1);
        tick();
        reset = 1'b1;
        dp_busy = 1'b0;
        repeat (4) tick();
        chk("rstcw_no_commit", act_sel(), 32'h0);

        // Reset while a response is outstanding
        send(4'd3, RD, 8'h00);
        chk("rstrs_pre", {31'h0, rsp_valid}, 32'h1);
        tick();
        reset = 1'b0;
        #2;
        chk("rstrs_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rstrs_data", {8'h0, rsp_data}, 32'h0);
        chk("rstrs_ready", {31'h0, cfg_ready}, 32'h1);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("rstrs_after", {31'h0, rsp_valid}, 32'h0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
